h1_row_accum: RTL
=================

# h1_row_accum

Consumes the 27 parallel 162-bit H1 sub-row words produced by the H1 ROM loader and combines them with a buffered 27-word message block. The output is 19 intermediate 162-bit parity vectors for the LDPC encoder's parity stage. The block also drives the loader's request strobe, so it owns the sequencing of one H1 sweep per message block. It sits between the message input interface and the parity back-substitution stage.

## Interface
- `ZW`, 162, sub-word width in bits (circulant size).
- `NCOL`, 27, message words per block; also the number of parallel H1 words per beat.
- `NROW`, 19, H1 beats per sweep; also the number of output vectors.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `msg_valid`  in  1  message word present.
- `msg_ready`  out  1  block accepts a message word.
- `msg_data`  in  ZW  message word. Words arrive in order k = 0..NCOL-1.
- `h_req`  out  1  drives the loader's `valid` input.
- `h_row`  in  NCOL x ZW  loader `register[26:0]` output.
- `valid_H`  in  1  loader's valid for `h_row`.
- `p_valid`  out  1  output vector valid, a single-cycle strobe per beat.
- `p_data`  out  ZW  output vector.
- `p_index`  out  5  row index 0..NROW-1 of `p_data`.
- `done`  out  1  one-cycle pulse, block finished.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Message buffer: NCOL x ZW registers `m[k]`, plus a word counter `wcnt` (0..NCOL-1).
- States are IDLE, LOAD, REQ, DRAIN.
- **IDLE**
  - `msg_ready` = 1.
  - The first accepted word (`msg_valid & msg_ready`) is written to `m[0]`, `wcnt` becomes 1, and the state goes to LOAD.
- **LOAD**
  - `msg_ready` = 1.
  - Each accepted word is written to `m[wcnt]` and `wcnt` increments.
  - On accepting word NCOL-1, `wcnt` clears and the state goes to REQ.
- **REQ**
  - `msg_ready` = 0 and `h_req` = 1.
  - `h_req` stays high for exactly NROW contiguous cycles, counted by `rcnt`, so the loader's address runs 0..18 without a gap.
  - After the NROW-th cycle the state goes to DRAIN, and `h_req` drops.
- **Beat consumption (REQ and DRAIN)**
  - The block consumes beats in REQ and DRAIN only.
  - On each `valid_H`, it computes `p = XOR over k of (h_row[k] & m[k])`, bitwise and ZW wide.
  - The result is registered to `p_data`, with `p_index` = `ocnt`, and `ocnt` increments.
- **Completion**
  - When the beat with `ocnt` = NROW-1 is consumed, the state goes to IDLE.
  - `done` pulses in the same cycle that `p_valid` carries index 18.
- **Stray beats:** `valid_H` is ignored in IDLE and LOAD, and any beat beyond NROW is ignored.
- **Backpressure:** the output has none. The downstream stage must accept every `p_valid` beat.
- **Buffer stability:** `m[]` is not modified outside IDLE and LOAD, so it stays stable while H rows stream.
- **Width rules:** `wcnt` is 5 bits and wraps at NCOL-1 to 0. `rcnt` and `ocnt` are 5 bits and stop at NROW-1. There is no arithmetic overflow path.

## Timing
- **Reset values:** state is IDLE, and `msg_ready` = 1. `h_req`, `p_valid`, `p_data`, `p_index`, `done`, `busy`, `wcnt`, `rcnt`, `ocnt` and `m[]` are all 0.
- **Reset mid-operation:** an asserted reset clears everything immediately and asynchronously, and `h_req` drops at once. The loader address then returns to 0 on its own because its `valid` is low.
- **Request start:** with the last message word accepted at cycle T, `h_req` is high in cycles T+1..T+NROW.
- **Output latency:** `p_valid` rises 1 cycle after each `valid_H`.
  - With the loader's ROM plus `valid_H` register, the first `p_valid` occurs no earlier than T+3.
  - The block does not depend on the exact loader latency; it counts `valid_H` beats.
- **Ready gap:** `msg_ready` returns to 1 in the cycle after `done`. The next block can be accepted then, so there is a minimum 1-cycle bubble between blocks.
- **Beat spacing:** `valid_H` beats may be non-contiguous (gaps tolerated). `done` still coincides with the 19th consumed beat.
- **Cycle exclusivity:**
  - `msg_valid` is never accepted in the same cycle that `h_req` is high.
  - `p_valid` and `msg_ready` are both high only in the `done` cycle's successor or later.

## Test plan
- **Reset check:** assert `rst` low for 3 cycles, then release. All outputs must hold their reset values, with `msg_ready` = 1 and `h_req` = 0.
- **All-ones:** all 27 message words `{162{1'b1}}`, H model returns all ones. Expect 19 `p_valid` beats, `p_index` 0..18, each `p_data` = all ones (27 is odd), and `done` with index 18. `h_req` must be high for exactly 19 cycles.
- **Single-bit selectivity:**
  - Set `m[k]` = bit k only, for k = 0..26. The H model sets `h_row[k]` = all ones when k == row index, else 0.
  - Expect `p_data[r]` = `1<<r` for r = 0..18.
- **Gappy `valid_H`:** insert 2 idle cycles between every beat. Expect outputs identical to the all-ones case, with `done` on the 19th beat, and stray `valid_H` in IDLE producing no `p_valid`.
- **Mid-load and mid-drain reset:**
  - Reset after 13 message words: the block returns to IDLE, and the next full block computes correctly from scratch.
  - Reset during beat 7 of DRAIN: `p_valid` stops immediately, and no `done` is produced.
- **Back-to-back blocks:** load the second block the cycle after `done`. It must produce 19 fresh beats, and no beat may mix the first block's message data.

Source files
------------

// File: rtl/h1_row_accum.sv
// h1_row_accum: buffers one 27-word message block, sequences one H1 sweep
// through the ROM loader, and folds every returned H1 beat against the
// buffered block into one 162-bit intermediate parity vector per beat.
module h1_row_accum #(
  parameter int ZW   = 162,
  parameter int NCOL = 27,
  parameter int NROW = 19
) (
  input  logic                      clk,
  input  logic                      rst,        // active-low, asynchronous
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  logic [ZW-1:0]             msg_data,
  output logic                      h_req,
  input  logic [NCOL-1:0][ZW-1:0]   h_row,
  input  logic                      valid_H,
  output logic                      p_valid,
  output logic [ZW-1:0]             p_data,
  output logic [4:0]                p_index,
  output logic                      done,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_REQ   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [4:0] LAST_W = 5'(NCOL - 1);
  localparam logic [4:0] LAST_R = 5'(NROW - 1);

  state_t            state_q, state_d;
  logic [4:0]        wcnt_q, wcnt_d;
  logic [4:0]        rcnt_q, rcnt_d;
  logic [4:0]        ocnt_q, ocnt_d;
  logic              p_valid_q, p_valid_d;
  logic [ZW-1:0]     p_data_q, p_data_d;
  logic [4:0]        p_index_q, p_index_d;
  logic              done_q, done_d;

  logic [ZW-1:0]     m_q [NCOL];
  logic [ZW-1:0]     prod [NCOL];
  logic [ZW-1:0]     parity;
  logic              msg_accept;
  logic              beat_take;
  logic [4:0]        m_widx;

  // Ready is held low during the done cycle so the last output beat never
  // overlaps with a new message acceptance.
  assign msg_ready  = ((state_q == S_IDLE) && !done_q) || (state_q == S_LOAD);
  assign msg_accept = msg_valid && msg_ready;
  assign beat_take  = valid_H && ((state_q == S_REQ) || (state_q == S_DRAIN));
  assign m_widx     = (state_q == S_IDLE) ? 5'd0 : wcnt_q;

  // One AND term per message column; the column terms are then XOR-folded.
  for (genvar gi = 0; gi < NCOL; gi++) begin : g_prod
    assign prod[gi] = h_row[gi] & m_q[gi];
  end

  // XOR reduction over all column products.
  always_comb begin
    parity = '0;
    for (int k = 0; k < NCOL; k++) begin
      parity = parity ^ prod[k];
    end
  end

  // Next-state, counters and output-register inputs.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    ocnt_d    = ocnt_q;
    p_valid_d = 1'b0;
    done_d    = 1'b0;
    p_data_d  = p_data_q;
    p_index_d = p_index_q;

    unique case (state_q)
      S_IDLE: begin
        if (msg_accept) begin
          wcnt_d  = 5'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (msg_accept) begin
          if (wcnt_q == LAST_W) begin
            wcnt_d  = 5'd0;
            state_d = S_REQ;
          end else begin
            wcnt_d = wcnt_q + 5'd1;
          end
        end
      end
      S_REQ: begin
        // Exactly NROW contiguous request cycles keep the loader address gap-free.
        if (rcnt_q == LAST_R) begin
          rcnt_d  = 5'd0;
          state_d = S_DRAIN;
        end else begin
          rcnt_d = rcnt_q + 5'd1;
        end
      end
      S_DRAIN: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Beats are counted, not timed, so any loader latency or gap pattern works.
    if (beat_take) begin
      p_valid_d = 1'b1;
      p_data_d  = parity;
      p_index_d = ocnt_q;
      if (ocnt_q == LAST_R) begin
        done_d  = 1'b1;
        ocnt_d  = 5'd0;
        rcnt_d  = 5'd0;
        state_d = S_IDLE;
      end else begin
        ocnt_d = ocnt_q + 5'd1;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= 5'd0;
      rcnt_q    <= 5'd0;
      ocnt_q    <= 5'd0;
      p_valid_q <= 1'b0;
      p_data_q  <= '0;
      p_index_q <= 5'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      ocnt_q    <= ocnt_d;
      p_valid_q <= p_valid_d;
      p_data_q  <= p_data_d;
      p_index_q <= p_index_d;
      done_q    <= done_d;
    end
  end

  // Message buffer; only written while accepting, so it is frozen during the sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCOL; k++) begin
        m_q[k] <= '0;
      end
    end else if (msg_accept) begin
      m_q[m_widx] <= msg_data;
    end
  end

  assign h_req   = (state_q == S_REQ);
  assign busy    = (state_q != S_IDLE);
  assign p_valid = p_valid_q;
  assign p_data  = p_data_q;
  assign p_index = p_index_q;
  assign done    = done_q;

endmodule
